// File: rtl/ro_puf_measure_core.sv
// rtl/ro_puf_measure_core.sv - ring-oscillator PUF measurement engine
module ro_puf_measure_core #(
    parameter int N_RO        = 16,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int SEL_W       = $clog2(N_RO)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    input  logic [WIN_W-1:0]  window,
    input  logic [N_RO-1:0]   ro_in,
    output logic [N_RO-1:0]   ro_en,
    output logic              busy,
    output logic              done,
    output logic              resp_bit,
    output logic              tie,
    output logic              err,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    typedef enum logic [2:0] {S_IDLE, S_ENABLE, S_COUNT, S_DRAIN, S_DONE} state_t;

    localparam logic [N_RO-1:0]  ONE_HOT0  = {{(N_RO-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(SYNC_STAGES - 1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   sel_a_q, sel_b_q;
    logic [WIN_W-1:0]   win_q, tmr;
    logic [CNT_W-1:0]   cnt_a_r, cnt_b_r;
    logic [N_RO-1:0]    sync_q [SYNC_STAGES];
    logic [N_RO-1:0]    sync_prev, rise, mask_a, mask_b;
    logic               rise_a, rise_b, bad_sel, tmr_zero;

    assign bad_sel  = (int'(sel_a) >= N_RO) || (int'(sel_b) >= N_RO);
    assign mask_a   = ONE_HOT0 << sel_a_q;
    assign mask_b   = ONE_HOT0 << sel_b_q;
    assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign rise_a   = |(rise & mask_a);
    assign rise_b   = |(rise & mask_b);
    assign tmr_zero = (tmr == '0);

    // Free-running synchronizer chain plus one edge-detect flop per RO input
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_prev <= '0;
        end else begin
            sync_q[0] <= ro_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        ro_en    = '0;
        case (state)
            S_IDLE:   if (start) state_nx = bad_sel ? S_DONE : S_ENABLE;
            S_ENABLE: begin
                busy  = 1'b1;
                ro_en = mask_a | mask_b;
                if (tmr_zero) state_nx = (win_q == '0) ? S_DRAIN : S_COUNT;
            end
            S_COUNT: begin
                busy  = 1'b1;
                ro_en = mask_a | mask_b;
                if (tmr_zero) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy  = 1'b1;
                ro_en = mask_a | mask_b;
                if (tmr_zero) state_nx = S_DONE;
            end
            S_DONE: begin
                // A rejected challenge spends its only busy cycle here
                done     = 1'b1;
                busy     = err;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // One down-counter times settle, window and drain phases in turn
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            win_q    <= '0;
            tmr      <= '0;
            cnt_a_r  <= '0;
            cnt_b_r  <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            resp_bit <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sel_a_q <= sel_a;
                    sel_b_q <= sel_b;
                    win_q   <= window;
                    tmr     <= SETTLE_LD;
                    if (bad_sel) begin
                        cnt_a    <= '0;
                        cnt_b    <= '0;
                        resp_bit <= 1'b0;
                        tie      <= 1'b0;
                        err      <= 1'b1;
                    end
                end
                S_ENABLE: begin
                    if (tmr_zero) begin
                        cnt_a_r <= '0;
                        cnt_b_r <= '0;
                        tmr     <= (win_q == '0) ? DRAIN_LD : win_q - 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_COUNT: begin
                    if (rise_a && cnt_a_r != '1) cnt_a_r <= cnt_a_r + 1'b1;
                    if (rise_b && cnt_b_r != '1) cnt_b_r <= cnt_b_r + 1'b1;
                    tmr <= tmr_zero ? DRAIN_LD : tmr - 1'b1;
                end
                S_DRAIN: begin
                    if (tmr_zero) begin
                        cnt_a    <= cnt_a_r;
                        cnt_b    <= cnt_b_r;
                        resp_bit <= (cnt_a_r > cnt_b_r);
                        tie      <= (cnt_a_r == cnt_b_r);
                        err      <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_measure_core.sv
// tb/tb_ro_puf_measure_core.sv - directed self-checking bench for ro_puf_measure_core
module tb_ro_puf_measure_core;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [3:0]  sel_a1 = '0, sel_b1 = '0;
    logic [4:0]  sel_a2 = '0, sel_b2 = '0;
    logic [15:0] window1 = '0, window2 = '0;
    logic        osc3 = 1'b0, osc5 = 1'b0, osc7 = 1'b0;
    logic [15:0] osc, ro_in1, ro_in2, ro_en1, ro_en2;
    logic        busy1, done1, resp1, tie1, err1;
    logic        busy2, done2, resp2, tie2, err2;
    logic [15:0] cnt_a1, cnt_b1;
    logic [3:0]  cnt_a2, cnt_b2;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;
    initial begin #1; forever #20 osc3 = ~osc3; end
    initial begin #1; forever #25 osc5 = ~osc5; end
    initial begin #1; forever #30 osc7 = ~osc7; end

    assign osc    = {8'b0, osc7, 1'b0, osc5, 1'b0, osc3, 3'b0};
    assign ro_in1 = osc & ro_en1;
    assign ro_in2 = osc & ro_en2;

    ro_puf_measure_core dut1 (
        .ACLK(aclk), .ARESETN(aresetn), .start(start1), .sel_a(sel_a1), .sel_b(sel_b1),
        .window(window1), .ro_in(ro_in1), .ro_en(ro_en1), .busy(busy1), .done(done1),
        .resp_bit(resp1), .tie(tie1), .err(err1), .cnt_a(cnt_a1), .cnt_b(cnt_b1)
    );

    ro_puf_measure_core #(.CNT_W(4), .SEL_W(5)) dut2 (
        .ACLK(aclk), .ARESETN(aresetn), .start(start2), .sel_a(sel_a2), .sel_b(sel_b2),
        .window(window2), .ro_in(ro_in2), .ro_en(ro_en2), .busy(busy2), .done(done2),
        .resp_bit(resp2), .tie(tie2), .err(err2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    // n counts cycles inclusively: the cycle start is driven is cycle 1
    task automatic run_wait(input int inst, input int n0, input int inj_at,
                            input logic [15:0] exp_mask, output int n, output bit to,
                            output bit en_bad, output bit busy_bad, output bit busy_at_done);
        logic        d_done, d_busy;
        logic [15:0] d_en;
        n = n0; to = 0; en_bad = 0; busy_bad = 0; busy_at_done = 0;
        while (1) begin
            @(negedge aclk);
            n++;
            if (n == 2) begin start1 = 1'b0; start2 = 1'b0; end
            if (inj_at != 0 && n == inj_at) begin
                start1 = 1'b1; sel_a1 = 4'd5; sel_b1 = 4'd5; window1 = 16'd10;
            end else if (inj_at != 0 && n == inj_at + 1) begin
                start1 = 1'b0;
            end
            d_done = (inst == 2) ? done2 : done1;
            d_busy = (inst == 2) ? busy2 : busy1;
            d_en   = (inst == 2) ? ro_en2 : ro_en1;
            if (d_done) begin
                if (d_en !== 16'h0) en_bad = 1;
                busy_at_done = d_busy;
                break;
            end
            if (!d_busy) busy_bad = 1;
            if (d_en !== exp_mask) en_bad = 1;
            if (n >= 2000) begin to = 1; break; end
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        tests++; if ({busy1, done1, resp1, tie1, err1, ro_en1, cnt_a1, cnt_b1} !== '0) begin
            fails++; $display("FAIL reset_dut1: got %h want 0", {busy1, done1, resp1, tie1, err1, ro_en1, cnt_a1, cnt_b1}); end
        tests++; if ({busy2, done2, resp2, tie2, err2, ro_en2, cnt_a2, cnt_b2} !== '0) begin
            fails++; $display("FAIL reset_dut2: got %h want 0", {busy2, done2, resp2, tie2, err2, ro_en2, cnt_a2, cnt_b2}); end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd3; sel_b1 = 4'd7; window1 = 16'd100;
        run_wait(1, 1, 0, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 112) begin fails++; $display("FAIL basic_latency: got %0d want 112", n); end
        tests++; if (cnt_a1 < 24 || cnt_a1 > 26) begin fails++; $display("FAIL basic_cnt_a: got %0d want 25+-1", cnt_a1); end
        tests++; if (cnt_b1 < 15 || cnt_b1 > 17) begin fails++; $display("FAIL basic_cnt_b: got %0d want 16+-1", cnt_b1); end
        tests++; if ({resp1, tie1, err1} !== 3'b100) begin fails++; $display("FAIL basic_flags: got %b want 100", {resp1, tie1, err1}); end
        tests++; if (eb || bb || bd) begin fails++; $display("FAIL basic_en_busy: got en_bad=%0d busy_bad=%0d busy_at_done=%0d want 0 0 0", eb, bb, bd); end
        @(negedge aclk);
        tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b want 0", done1); end
    endtask

    task automatic test_swapped;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd7; sel_b1 = 4'd3; window1 = 16'd100;
        run_wait(1, 1, 0, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 112) begin fails++; $display("FAIL swap_latency: got %0d want 112", n); end
        tests++; if (cnt_a1 < 15 || cnt_a1 > 17 || cnt_b1 < 24 || cnt_b1 > 26) begin
            fails++; $display("FAIL swap_counts: got %0d/%0d want 16+-1/25+-1", cnt_a1, cnt_b1); end
        tests++; if ({resp1, tie1, err1} !== 3'b000) begin fails++; $display("FAIL swap_flags: got %b want 000", {resp1, tie1, err1}); end
        @(negedge aclk);
    endtask

    task automatic test_same_index;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd5; sel_b1 = 4'd5; window1 = 16'd100;
        run_wait(1, 1, 0, 16'h0020, n, to, eb, bb, bd);
        tests++; if (to || cnt_a1 !== cnt_b1 || cnt_a1 < 19 || cnt_a1 > 21) begin
            fails++; $display("FAIL same_counts: got %0d/%0d want equal 20+-1", cnt_a1, cnt_b1); end
        tests++; if ({resp1, tie1, err1, eb} !== 4'b0100) begin fails++; $display("FAIL same_flags: got %b want 0100", {resp1, tie1, err1, eb}); end
        @(negedge aclk);
    endtask

    task automatic test_window_zero;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd3; sel_b1 = 4'd7; window1 = 16'd0;
        run_wait(1, 1, 0, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 12) begin fails++; $display("FAIL win0_latency: got %0d want 12", n); end
        tests++; if ({cnt_a1, cnt_b1} !== 32'h0 || {resp1, tie1, err1} !== 3'b010) begin
            fails++; $display("FAIL win0_result: got %0d/%0d flags %b want 0/0 flags 010", cnt_a1, cnt_b1, {resp1, tie1, err1}); end
        @(negedge aclk);
    endtask

    task automatic test_bad_index;
        int n; bit to, eb, bb, bd;
        start2 = 1'b1; sel_a2 = 5'd3; sel_b2 = 5'd20; window2 = 16'd100;
        run_wait(2, 1, 0, 16'h0000, n, to, eb, bb, bd);
        tests++; if (to || n !== 2) begin fails++; $display("FAIL bad_latency: got %0d want 2", n); end
        tests++; if ({err2, resp2, tie2, cnt_a2, cnt_b2} !== 11'b100_0000_0000) begin
            fails++; $display("FAIL bad_result: got %b want 10000000000", {err2, resp2, tie2, cnt_a2, cnt_b2}); end
        tests++; if (eb || !bd) begin fails++; $display("FAIL bad_en_busy: got en_bad=%0d busy_at_done=%0d want 0 1", eb, bd); end
        @(negedge aclk);
        tests++; if ({busy2, done2} !== 2'b00) begin fails++; $display("FAIL bad_after: got %b want 00", {busy2, done2}); end
    endtask

    task automatic test_saturation;
        int n; bit to, eb, bb, bd;
        start2 = 1'b1; sel_a2 = 5'd3; sel_b2 = 5'd7; window2 = 16'd200;
        run_wait(2, 1, 0, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 212) begin fails++; $display("FAIL sat_latency: got %0d want 212", n); end
        tests++; if (cnt_a2 !== 4'd15 || cnt_b2 !== 4'd15) begin fails++; $display("FAIL sat_counts: got %0d/%0d want 15/15", cnt_a2, cnt_b2); end
        tests++; if ({err2, tie2, resp2} !== 3'b010) begin fails++; $display("FAIL sat_flags: got %b want 010", {err2, tie2, resp2}); end
        @(negedge aclk);
    endtask

    task automatic test_start_while_busy;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd3; sel_b1 = 4'd7; window1 = 16'd100;
        run_wait(1, 1, 50, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 112 || eb) begin fails++; $display("FAIL busy_start_latency: got %0d en_bad=%0d want 112 0", n, eb); end
        tests++; if (cnt_a1 < 24 || cnt_a1 > 26 || cnt_b1 < 15 || cnt_b1 > 17 || resp1 !== 1'b1) begin
            fails++; $display("FAIL busy_start_result: got %0d/%0d resp %b want 25/16 resp 1", cnt_a1, cnt_b1, resp1); end
        @(negedge aclk);
    endtask

    task automatic test_back_to_back;
        int n; bit to, eb, bb, bd;
        start1 = 1'b1; sel_a1 = 4'd7; sel_b1 = 4'd3; window1 = 16'd100;
        run_wait(1, 1, 0, 16'h0088, n, to, eb, bb, bd);
        @(negedge aclk);
        start1 = 1'b1; sel_a1 = 4'd3; sel_b1 = 4'd7; window1 = 16'd100;
        @(negedge aclk);
        start1 = 1'b0;
        repeat (40) @(negedge aclk);
        tests++; if (busy1 !== 1'b1 || resp1 !== 1'b0 || cnt_a1 < 15 || cnt_a1 > 17) begin
            fails++; $display("FAIL b2b_hold: got busy %b resp %b cnt_a %0d want 1 0 16+-1", busy1, resp1, cnt_a1); end
        run_wait(1, 42, 0, 16'h0088, n, to, eb, bb, bd);
        tests++; if (to || n !== 112) begin fails++; $display("FAIL b2b_latency: got %0d want 112", n); end
        tests++; if (resp1 !== 1'b1 || cnt_a1 < 24 || cnt_a1 > 26) begin
            fails++; $display("FAIL b2b_result: got resp %b cnt_a %0d want 1 25+-1", resp1, cnt_a1); end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid_run;
        bit seen = 0;
        start1 = 1'b1; sel_a1 = 4'd3; sel_b1 = 4'd7; window1 = 16'd100;
        @(negedge aclk);
        start1 = 1'b0;
        repeat (58) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        tests++; if ({busy1, done1, resp1, tie1, err1, ro_en1, cnt_a1, cnt_b1} !== '0) begin
            fails++; $display("FAIL midrst_outputs: got %h want 0", {busy1, done1, resp1, tie1, err1, ro_en1, cnt_a1, cnt_b1}); end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge aclk);
            if (done1 || busy1) seen = 1;
        end
        tests++; if (seen) begin fails++; $display("FAIL midrst_no_done: got activity=1 want 0"); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_swapped;
        test_same_index;
        test_window_zero;
        test_bad_index;
        test_saturation;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
